// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Shared CPU definitions for the memory-stage responders:
//                data-memory FSM state encoding, default latency/depth and
//                a helper that sizes the wait counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int DMEM_LATENCY_DEFAULT = 3;
    localparam int DMEM_DEPTH_DEFAULT   = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // The counter is loaded with LATENCY-1 at most, so clog2(LATENCY) bits
    // suffice; keep at least one bit so LATENCY==1 builds stay legal.
    function automatic int dmem_cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage : cpu_defs
`default_nettype wire

// File: rtl/dmem_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_wait_counter
//  Description : Loadable down-counter used to time multi-cycle memory
//                accesses. Flags when the count has reached one so the owning
//                FSM can leave its wait state on that edge.
//  Ports       : clk_i      - clock
//                rst_i      - synchronous, active-low reset (count -> 0)
//                load_i     - load load_val_i (has priority over dec_i)
//                load_val_i - value to load
//                dec_i      - decrement by one (saturates at zero)
//                is_one_o   - count == 1
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (dec_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign is_one_o = (r_cnt == WIDTH'(1));

endmodule : dmem_wait_counter
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the MEM stage. Holds a
//                word-addressed RAM, serves one access at a time with a fixed
//                LATENCY and requests a pipeline freeze until it completes.
//  Ports       : clk_i      - clock
//                rst_i      - synchronous, active-low reset
//                MemRead_i  - read request from EX/MEM
//                MemWrite_i - write request from EX/MEM (wins over read)
//                addr_i     - byte address, bits [1:0] ignored, wraps on depth
//                data_i     - write data
//                data_o     - registered read data, held until next read
//                stall_o    - pipeline freeze request (combinational)
//                ack_o      - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import cpu_defs::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
    parameter int LATENCY     = DMEM_LATENCY_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o
);

    localparam int c_ADDR_W = $clog2(DEPTH_WORDS);
    localparam int c_CNT_W  = dmem_cnt_width(LATENCY);

    // RAM is deliberately left without reset.
    logic [31:0] memory [DEPTH_WORDS];

    dmem_state_t         r_state;
    dmem_state_t         w_state_next;

    logic                r_ack;
    logic [31:0]         r_data;

    logic                r_op_write;
    logic [c_ADDR_W-1:0] r_idx;
    logic [31:0]         r_wdata;

    logic                w_req;
    logic [c_ADDR_W-1:0] w_in_idx;
    logic                w_accept;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_cnt_is_one;
    logic                w_commit;
    logic                w_stall;

    logic                w_cm_write;
    logic [c_ADDR_W-1:0] w_cm_idx;
    logic [31:0]         w_cm_data;

    logic                w_unused_addr_bits;

    assign w_req              = MemRead_i | MemWrite_i;
    assign w_in_idx           = addr_i[c_ADDR_W+1:2];
    assign w_unused_addr_bits = ^{addr_i[31:c_ADDR_W+2], addr_i[1:0]};

    // ------------------------------------------------------------------------
    // Wait counter: loaded with LATENCY-1 on acceptance, counts BUSY cycles.
    // ------------------------------------------------------------------------
    dmem_wait_counter #(
        .WIDTH      (c_CNT_W)
    ) u_wait_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_cnt_load),
        .load_val_i (c_CNT_W'(LATENCY - 1)),
        .dec_i      (w_cnt_dec),
        .is_one_o   (w_cnt_is_one)
    );

    // ------------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_commit     = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    if (LATENCY == 1) begin
                        // Single-cycle build: the accepting edge is also
                        // the commit edge.
                        w_state_next = DONE;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = BUSY;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (w_cnt_is_one) begin
                    w_state_next = DONE;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DONE: begin
                // Pipeline advances this cycle; any request is the stale one.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // When committing straight out of IDLE (LATENCY==1) the latched copies
    // are not yet loaded, so take the live inputs instead.
    assign w_cm_write = (r_state == IDLE) ? MemWrite_i : r_op_write;
    assign w_cm_idx   = (r_state == IDLE) ? w_in_idx   : r_idx;
    assign w_cm_data  = (r_state == IDLE) ? data_i     : r_wdata;

    // ------------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= (w_state_next == DONE);
            if (w_commit && !w_cm_write) begin
                r_data <= memory[w_cm_idx];
            end
        end
    end

    // Request capture; inputs are ignored after acceptance.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_op_write <= MemWrite_i;
            r_idx      <= w_in_idx;
            r_wdata    <= data_i;
        end
    end

    // RAM write port; a reset on the commit edge drops the write.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_commit && w_cm_write) begin
            memory[w_cm_idx] <= w_cm_data;
        end
    end

    // Stall is held low while reset is asserted so the pipeline is not
    // frozen by a request present during reset.
    assign stall_o = rst_i & w_stall;
    assign ack_o   = r_ack;
    assign data_o  = r_data;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Two instances
//                (LATENCY 3 and 1) share one stimulus stream and are checked
//                every cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic [31:0] dout0, dout1;
    logic        stall0, stall1, ack0, ack1;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .addr_i(addr), .data_i(wdata), .data_o(dout0), .stall_o(stall0), .ack_o(ack0)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .addr_i(addr), .data_i(wdata), .data_o(dout1), .stall_o(stall1), .ack_o(ack1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: one pending transaction per instance, timed by its
    // start cycle; memory contents mirrored in plain arrays.
    logic [31:0] mm [2][256];
    bit          act [2];
    int          st [2];
    bit          opw [2];
    logic [7:0]  midx [2];
    logic [31:0] mwd [2];
    logic [31:0] edata [2];
    bit          armed = 1'b0;

    int          m_lat;
    int          m_k;
    logic        m_es;
    logic        m_ea;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_lat = (i == 0) ? 3 : 1;
            m_k   = act[i] ? (cyc - st[i]) : -1;
            m_ea  = act[i] && (m_k == m_lat);
            m_es  = 1'b0;
            if (rst_n) begin
                if (act[i] && (m_k < m_lat)) begin
                    m_es = 1'b1;
                end else if (!act[i] && (mem_read || mem_write)) begin
                    act[i]  = 1'b1;
                    st[i]   = cyc;
                    m_k     = 0;
                    m_es    = 1'b1;
                    opw[i]  = mem_write;
                    midx[i] = addr[9:2];
                    mwd[i]  = wdata;
                end
            end
            if (armed) begin
                chk((i == 0) ? "model_stall0" : "model_stall1", (i == 0) ? stall0 : stall1, m_es);
                chk((i == 0) ? "model_ack0" : "model_ack1", (i == 0) ? ack0 : ack1, m_ea);
                chk((i == 0) ? "model_data0" : "model_data1", (i == 0) ? dout0 : dout1, edata[i]);
            end
            if (!rst_n) begin
                act[i]   = 1'b0;
                edata[i] = '0;
            end else if (act[i]) begin
                if (m_k == m_lat - 1) begin
                    if (opw[i]) mm[i][midx[i]] = mwd[i];
                    else        edata[i] = mm[i][midx[i]];
                end
                if (m_k == m_lat) act[i] = 1'b0;
            end
        end
        if (!rst_n) armed = 1'b1;
    end

    // Issue one access on the LATENCY-3 instance, holding the request until
    // its ack as a frozen pipeline would.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit use_alt,
                          input logic [31:0] alt_a, input logic [31:0] alt_d,
                          output int n_stall, output logic [31:0] d_at_ack);
        bit got;
        got      = 1'b0;
        n_stall  = 0;
        d_at_ack = '0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall0) n_stall++;
            if (ack0) begin
                d_at_ack = dout0;
                got      = 1'b1;
                break;
            end
            if (c == 0 && use_alt) begin
                @(posedge clk); #1;
                addr = alt_a; wdata = alt_d;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    int          ns;
    logic [31:0] dv;
    logic [31:0] v;
    int          r;

    initial begin
        for (int j = 0; j < 256; j++) begin
            v = $urandom(); dut0.memory[j] = v; mm[0][j] = v;
            v = $urandom(); dut1.memory[j] = v; mm[1][j] = v;
        end
        dut0.memory[5]  = 32'hA5A5_0001; mm[0][5]  = 32'hA5A5_0001;
        dut0.memory[16] = 32'h1600_0016; mm[0][16] = 32'h1600_0016;
        dut0.memory[4]  = 32'h0400_0004; mm[0][4]  = 32'h0400_0004;

        // Reset with a write request present.
        rst_n = 1'b0; mem_write = 1'b1; addr = 32'h14; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall", stall0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        chk("rst_ack", ack0, 1'b0);
        chk("rst_data", dout0, 32'h0);
        chk("rst_mem5", dut0.memory[5], 32'hA5A5_0001);

        // Write then read back.
        access(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF, 1'b0, 0, 0, ns, dv);
        chk("wr_stall_cycles", ns, 3);
        @(negedge clk);
        chk("ack_one_cycle", ack0, 1'b0);
        access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 0, 0, ns, dv);
        chk("rd_data", dv, 32'hDEAD_BEEF);
        chk("rd_stall_cycles", ns, 3);

        // Address wrap and ignored low bits.
        access(1'b0, 1'b1, 32'h400, 32'h1, 1'b0, 0, 0, ns, dv);
        chk("wrap_mem0", dut0.memory[0], 32'h1);
        access(1'b1, 1'b0, 32'h3, 32'h0, 1'b0, 0, 0, ns, dv);
        chk("misalign_rd", dv, 32'h1);

        // Read+write together behaves as a write.
        access(1'b1, 1'b1, 32'hC, 32'h55, 1'b0, 0, 0, ns, dv);
        chk("rw_data_held", dv, 32'h1);
        chk("rw_mem3", dut0.memory[3], 32'h55);

        // Inputs changing while busy are ignored.
        access(1'b0, 1'b1, 32'h8, 32'h11, 1'b1, 32'h40, 32'h99, ns, dv);
        chk("busy_mem2", dut0.memory[2], 32'h11);
        chk("busy_mem16", dut0.memory[16], 32'h1600_0016);

        // Reset in the first BUSY cycle cancels the write.
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h10; wdata = 32'h77;
        @(posedge clk); #1;
        rst_n = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("midrst_stall_in_rst", stall0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_stall_after", stall0, 1'b0);
        chk("midrst_mem4", dut0.memory[4], 32'h0400_0004);

        // LATENCY=1 instance timing.
        repeat (5) @(posedge clk);
        #1;
        mem_read = 1'b1; addr = 32'h14;
        @(negedge clk);
        chk("l1_stall", stall1, 1'b1);
        chk("l1_ack_early", ack1, 1'b0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("l1_stall_done", stall1, 1'b0);
        chk("l1_ack", ack1, 1'b1);
        chk("l1_data", dout1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("l1_ack_pulse", ack1, 1'b0);
        repeat (5) @(posedge clk);

        // Randomized traffic, including wrapped addresses and resets.
        repeat (3000) begin
            @(posedge clk); #1;
            rst_n     = ($urandom_range(0, 199) != 0);
            r         = $urandom_range(0, 9);
            mem_read  = (r < 3) || (r == 6);
            mem_write = ((r >= 3) && (r < 6)) || (r == 6);
            addr      = $urandom();
            wdata     = $urandom();
        end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 256; j++) begin
            chk("final_mem0", dut0.memory[j], mm[0][j]);
            chk("final_mem1", dut1.memory[j], mm[1][j]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
